// File: rtl/weight_loader.sv
// Double-buffered, checksum-verified weight loader: a framed LW-bit stream fills a shadow
// buffer, and a verified frame replaces the active weights only when the datapath allows a swap.
module weight_loader #(
  parameter int unsigned WEIGHTS_B = 12864,
  parameter int unsigned LW        = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [LW-1:0]        s_data,
  input  logic                 s_last,
  input  logic                 swap_en,
  output logic [WEIGHTS_B-1:0] weights,
  output logic                 weights_valid,
  output logic                 load_done,
  output logic                 load_err,
  output logic                 busy
);

  localparam int unsigned N_WORDS = (WEIGHTS_B + LW - 1) / LW;
  localparam int unsigned CW      = $clog2(N_WORDS + 1);
  localparam int unsigned SB      = N_WORDS * LW;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_CSUM   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_count;
  logic [LW-1:0]          r_csum;
  logic [SB-1:0]          r_shadow;
  logic [WEIGHTS_B-1:0]   r_active;
  logic                   r_valid;
  logic                   r_done;
  logic                   r_err;
  logic                   r_busy;

  logic                   w_beat;
  logic [SB-1:0]          w_shadow_next;

  // Ready depends on state only; COMMIT holds off the stream until the swap happens.
  assign s_ready = (r_state != ST_COMMIT);
  assign w_beat  = s_valid & s_ready;

  // New words enter at the top so the first word of a frame ends up at the bottom.
  generate
    if (N_WORDS == 1) begin : g_one_word
      assign w_shadow_next = s_data;
    end else begin : g_shift
      assign w_shadow_next = {s_data, r_shadow[SB-1:LW]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_LOAD;
      r_count  <= '0;
      r_csum   <= '0;
      r_shadow <= '0;
      r_active <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (w_beat) begin
            if (s_last) begin
              // Frame ended before all data words arrived.
              r_err   <= 1'b1;
              r_count <= '0;
              r_csum  <= '0;
              r_busy  <= 1'b0;
            end else begin
              r_shadow <= w_shadow_next;
              r_csum   <= LW'(r_csum + s_data);
              r_busy   <= 1'b1;
              if (r_count == CW'(N_WORDS - 1)) begin
                r_count <= CW'(N_WORDS);
                r_state <= ST_CSUM;
              end else begin
                r_count <= r_count + CW'(1);
              end
            end
          end
        end
        ST_CSUM: begin
          if (w_beat) begin
            if (s_last && (s_data == r_csum)) begin
              r_state <= ST_COMMIT;
            end else begin
              r_err   <= 1'b1;
              r_count <= '0;
              r_csum  <= '0;
              r_busy  <= 1'b0;
              r_state <= ST_LOAD;
            end
          end
        end
        ST_COMMIT: begin
          if (swap_en) begin
            r_active <= r_shadow[WEIGHTS_B-1:0];
            r_valid  <= 1'b1;
            r_done   <= 1'b1;
            r_count  <= '0;
            r_csum   <= '0;
            r_busy   <= 1'b0;
            r_state  <= ST_LOAD;
          end
        end
        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

  assign weights       = r_active;
  assign weights_valid = r_valid;
  assign load_done     = r_done;
  assign load_err      = r_err;
  assign busy          = r_busy;

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: a small 20-bit/8-bit instance for directed and random
// frames, and a 12864-bit/1-bit instance for long back-to-back frames with stalls.
module tb_weight_loader;

  localparam int unsigned AW = 20;
  localparam int unsigned AL = 8;
  localparam int unsigned BW = 12864;
  localparam int unsigned BL = 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          a_valid, a_ready, a_last, a_swap, a_wv, a_done, a_err, a_busy;
  logic [AL-1:0] a_data;
  logic [AW-1:0] a_weights;

  logic          b_valid, b_ready, b_last, b_swap, b_wv, b_done, b_err, b_busy;
  logic [BL-1:0] b_data;
  logic [BW-1:0] b_weights;

  weight_loader #(.WEIGHTS_B(AW), .LW(AL)) u_a (
    .clk(clk), .rstn(rstn), .s_valid(a_valid), .s_ready(a_ready), .s_data(a_data),
    .s_last(a_last), .swap_en(a_swap), .weights(a_weights), .weights_valid(a_wv),
    .load_done(a_done), .load_err(a_err), .busy(a_busy)
  );

  weight_loader #(.WEIGHTS_B(BW), .LW(BL)) u_b (
    .clk(clk), .rstn(rstn), .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data),
    .s_last(b_last), .swap_en(b_swap), .weights(b_weights), .weights_valid(b_wv),
    .load_done(b_done), .load_err(b_err), .busy(b_busy)
  );

  int errors = 0;
  int checks = 0;

  // Expected outcome per frame: 1 = reject, 0 = commit with the given weights.
  bit            aq_err[$];
  logic [AW-1:0] aq_w[$];
  bit            bq_err[$];
  logic [BW-1:0] bq_w[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: ready never asserted at %0t", nm, $time);
  endtask

  // Monitor for the small instance.
  always @(negedge clk) begin
    if (rstn && (a_done || a_err)) begin
      checks++;
      if (a_done && a_err) begin
        errors++;
        $display("FAIL a_both_pulses: done=%0b err=%0b at %0t", a_done, a_err, $time);
      end else if (aq_err.size() == 0) begin
        errors++;
        $display("FAIL a_spurious_pulse: done=%0b err=%0b with nothing expected at %0t",
                 a_done, a_err, $time);
      end else begin
        bit            e_err;
        logic [AW-1:0] e_w;
        e_err = aq_err.pop_front();
        e_w   = aq_w.pop_front();
        if (a_err !== e_err) begin
          errors++;
          $display("FAIL a_event_kind: err=%0b expected err=%0b at %0t", a_err, e_err, $time);
        end else if (!e_err && (a_weights !== e_w)) begin
          errors++;
          $display("FAIL a_commit_weights: got %0h expected %0h at %0t", a_weights, e_w, $time);
        end
      end
    end
  end

  // Monitor for the wide instance.
  always @(negedge clk) begin
    if (rstn && (b_done || b_err)) begin
      checks++;
      if (b_done && b_err) begin
        errors++;
        $display("FAIL b_both_pulses: done=%0b err=%0b at %0t", b_done, b_err, $time);
      end else if (bq_err.size() == 0) begin
        errors++;
        $display("FAIL b_spurious_pulse: done=%0b err=%0b with nothing expected at %0t",
                 b_done, b_err, $time);
      end else begin
        bit            e_err;
        logic [BW-1:0] e_w;
        e_err = bq_err.pop_front();
        e_w   = bq_w.pop_front();
        if (b_err !== e_err) begin
          errors++;
          $display("FAIL b_event_kind: err=%0b expected err=%0b at %0t", b_err, e_err, $time);
        end else if (!e_err && (b_weights !== e_w)) begin
          int first_bad;
          first_bad = -1;
          for (int i = BW - 1; i >= 0; i--) if (b_weights[i] !== e_w[i]) first_bad = i;
          errors++;
          $display("FAIL b_commit_weights: first differing bit %0d got %0b expected %0b at %0t",
                   first_bad, b_weights[first_bad], e_w[first_bad], $time);
        end
      end
    end
  end

  // One handshake beat on the small instance after `gap` idle cycles with garbage on the bus.
  task automatic a_beat(input logic [AL-1:0] d, input logic l, input int gap);
    int n;
    a_valid = 1'b0;
    repeat (gap) begin
      a_data = AL'($urandom);
      a_last = 1'($urandom);
      @(posedge clk); #1;
    end
    a_valid = 1'b1;
    a_data  = d;
    a_last  = l;
    n = 0;
    while (!a_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) timeout_fail("a_ready_timeout");
    @(posedge clk); #1;
    a_valid = 1'b0;
    a_data  = AL'($urandom);
    a_last  = 1'b0;
  endtask

  // Three data words plus a checksum word; the model decides commit vs reject.
  task automatic a_frame(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                         input logic [7:0] ck, input int maxgap);
    int unsigned sum;
    logic [23:0] img;
    sum = (int'(w0) + int'(w1) + int'(w2)) % 256;
    img = {w2, w1, w0};
    aq_err.push_back(int'(ck) != sum);
    aq_w.push_back(img[AW-1:0]);
    a_beat(w0, 1'b0, $urandom_range(0, maxgap));
    a_beat(w1, 1'b0, $urandom_range(0, maxgap));
    a_beat(w2, 1'b0, $urandom_range(0, maxgap));
    a_beat(ck, 1'b1, $urandom_range(0, maxgap));
  endtask

  // Frame terminated by s_last on data word k (1..3): always rejected.
  task automatic a_early(input int k, input int maxgap);
    aq_err.push_back(1'b1);
    aq_w.push_back('0);
    for (int i = 0; i < k; i++) a_beat(AL'($urandom), (i == k - 1), $urandom_range(0, maxgap));
  endtask

  task automatic b_beat(input logic d, input logic l, input int gap);
    int n;
    b_valid = 1'b0;
    repeat (gap) begin
      b_data = 1'($urandom);
      b_last = 1'($urandom);
      @(posedge clk); #1;
    end
    b_valid = 1'b1;
    b_data  = d;
    b_last  = l;
    n = 0;
    while (!b_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) timeout_fail("b_ready_timeout");
    @(posedge clk); #1;
    b_valid = 1'b0;
    b_last  = 1'b0;
  endtask

  // Full random 1-bit frame; the checksum of single bits is the count of ones mod 2.
  task automatic b_frame();
    logic [BW-1:0] w;
    int ones;
    ones = 0;
    for (int i = 0; i < BW; i++) begin
      w[i] = 1'($urandom);
      ones += int'(w[i]);
    end
    bq_err.push_back(1'b0);
    bq_w.push_back(w);
    for (int i = 0; i < BW; i++) b_beat(w[i], 1'b0, $urandom_range(0, 2));
    b_beat(1'(ones % 2), 1'b1, $urandom_range(0, 2));
  endtask

  task automatic b_early(input int k);
    bq_err.push_back(1'b1);
    bq_w.push_back('0);
    for (int i = 0; i < k; i++) b_beat(1'($urandom), (i == k - 1), $urandom_range(0, 2));
  endtask

  task automatic a_check_idle_outputs(input string tag);
    chk({tag, "_weights"}, 64'(a_weights), 64'h0);
    chk({tag, "_wvalid"}, 64'(a_wv), 64'h0);
    chk({tag, "_done"}, 64'(a_done), 64'h0);
    chk({tag, "_err"}, 64'(a_err), 64'h0);
    chk({tag, "_busy"}, 64'(a_busy), 64'h0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_valid = 1'b0; a_data = '0; a_last = 1'b0; a_swap = 1'b1;
    b_valid = 1'b0; b_data = '0; b_last = 1'b0; b_swap = 1'b1;
    rstn = 1'b0;
    #12;
    a_check_idle_outputs("reset");
    chk("reset_ready", 64'(a_ready), 64'h1);
    chk("reset_b_wvalid", 64'(b_wv), 64'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Bad checksum after reset: rejected, nothing committed.
    a_frame(8'h11, 8'h22, 8'h33, 8'h67, 0);
    chk("bad_csum_err", 64'(a_err), 64'h1);
    chk("bad_csum_weights", 64'(a_weights), 64'h0);
    chk("bad_csum_wvalid", 64'(a_wv), 64'h0);
    chk("bad_csum_busy", 64'(a_busy), 64'h0);

    // Good frame: weights change one edge after the checksum beat.
    a_frame(8'h11, 8'h22, 8'h33, 8'h66, 0);
    chk("good_weights_before_swap", 64'(a_weights), 64'h0);
    chk("good_ready_in_commit", 64'(a_ready), 64'h0);
    @(posedge clk); #1;
    chk("good_weights", 64'(a_weights), 64'h32211);
    chk("good_done", 64'(a_done), 64'h1);
    chk("good_wvalid", 64'(a_wv), 64'h1);
    chk("good_busy_low", 64'(a_busy), 64'h0);
    @(posedge clk); #1;
    chk("good_done_one_cycle", 64'(a_done), 64'h0);

    // Early last on the second word, then a recovered frame.
    a_early(2, 0);
    chk("early_err", 64'(a_err), 64'h1);
    chk("early_weights_kept", 64'(a_weights), 64'h32211);
    a_frame(8'hAA, 8'hBB, 8'hCC, 8'h31, 0);
    @(posedge clk); #1;
    chk("recover_weights", 64'(a_weights), 64'hCBBAA);

    // Swap held off for five cycles.
    a_swap = 1'b0;
    a_frame(8'h01, 8'h02, 8'h03, 8'h06, 1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_ready_low", 64'(a_ready), 64'h0);
      chk("hold_weights_kept", 64'(a_weights), 64'hCBBAA);
      chk("hold_no_done", 64'(a_done), 64'h0);
      @(posedge clk); #1;
    end
    a_swap = 1'b1;
    @(posedge clk); #1;
    chk("hold_swap_weights", 64'(a_weights), 64'h30201);
    chk("hold_swap_done", 64'(a_done), 64'h1);

    // Reset in the middle of a frame discards the partial data.
    a_beat(8'h44, 1'b0, 0);
    a_beat(8'h55, 1'b0, 0);
    chk("mid_busy_high", 64'(a_busy), 64'h1);
    rstn = 1'b0;
    #1;
    a_check_idle_outputs("mid_reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    a_frame(8'h12, 8'h34, 8'h56, 8'h9C, 0);
    @(posedge clk); #1;
    chk("post_reset_weights", 64'(a_weights), 64'h63412);
    chk("post_reset_wvalid", 64'(a_wv), 64'h1);

    // Random mix of good, bad-checksum and early-last frames, back to back with stalls.
    for (int f = 0; f < 40; f++) begin
      int kind;
      logic [7:0] w0, w1, w2, ck;
      kind = $urandom_range(0, 3);
      w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom);
      ck = 8'(w0 + w1 + w2);
      if (kind == 0) a_early($urandom_range(1, 3), 2);
      else if (kind == 1) a_frame(w0, w1, w2, 8'(ck + 8'($urandom_range(1, 255))), 2);
      else a_frame(w0, w1, w2, ck, $urandom_range(0, 2));
    end
    repeat (3) @(posedge clk);
    #1;
    chk("a_queue_drained", 64'(aq_err.size()), 64'h0);

    // Wide 1-bit instance: good, early-last reject, good, back to back.
    b_frame();
    b_early(5);
    b_frame();
    repeat (3) @(posedge clk);
    #1;
    chk("b_wvalid", 64'(b_wv), 64'h1);
    chk("b_busy_low", 64'(b_busy), 64'h0);
    chk("b_queue_drained", 64'(bq_err.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
